// File: rtl/i2c_oled_tx.sv
// ---------------------------------------------------------------------------
// i2c_oled_tx
// I2C write-transaction engine sitting behind the OLED setup stage. One
// accepted request produces: START, {addr,R/W#}, control byte, command byte,
// STOP. Every byte is followed by an ACK slot; a NACK aborts to STOP.
//
// Optional feature (compile-time macro OLED_NACK_RETRY_EN):
//   a NACK issues STOP and restarts the whole frame from START with the
//   latched bytes, up to MAX_RETRY times. nack_err is only raised once the
//   retries are used up. Without the macro the first NACK ends the frame.
//
// Ports
//   CLK            system clock, all logic on posedge
//   RST            asynchronous active-high reset
//   start          request pulse, accepted only while busy==0
//   slave_addr     7-bit slave address
//   read_write     R/W# bit appended to the address
//   control_frame  control byte (Co, D/C#)
//   reg_addr       command byte
//   sda_in         synchronised SDA level, sampled in ACK slots
//   scl_out        SCL level (1 = released)
//   sda_oe         1 = pull SDA low, 0 = release
//   busy           transaction in progress
//   done           one-cycle pulse at transaction end
//   nack_err       sticky NACK abort flag, cleared by the next accepted start
//   state          bus phase, shared encoding with the setup stage
// ---------------------------------------------------------------------------
module i2c_oled_tx #(
    parameter int CLK_DIV   = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [6:0] slave_addr,
    input  logic       read_write,
    input  logic [7:0] control_frame,
    input  logic [7:0] reg_addr,
    input  logic       sda_in,
    output logic       scl_out,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       nack_err,
    output logic [3:0] state
);
    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        START         = 4'd1,
        RECOGNITION   = 4'd2,
        WRITE_CONTROL = 4'd3,
        WRITE_COMMAND = 4'd4,
        ACKNOWLEDGE   = 4'd7,
        STOP          = 4'd8
    } state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [1:0]       phase_reg, phase_next;
    logic [2:0]       bit_reg, bit_next;
    logic [1:0]       byte_idx_reg, byte_idx_next;
    logic             ack_reg, ack_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             nack_err_reg, nack_err_next;
    logic             scl_reg, scl_next;
    logic             sda_oe_reg, sda_oe_next;
    logic [7:0]       addr_byte_reg, ctrl_byte_reg, cmd_byte_reg;
    logic [7:0]       sel_byte;
    logic             load;
    logic             slot_end;
    logic             ack_point;

    // MAX_RETRY only shapes the retry build; a negative value is meaningless.
    if (MAX_RETRY < 0) begin : g_retry_cfg_unused
    end

`ifdef OLED_NACK_RETRY_EN
    localparam int RTRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RTRY_W-1:0] retry_reg, retry_next;
    logic              retry_pend_reg, retry_pend_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            retry_reg      <= '0;
            retry_pend_reg <= 1'b0;
        end else begin
            retry_reg      <= retry_next;
            retry_pend_reg <= retry_pend_next;
        end
    end
`endif

    assign slot_end  = (div_reg == DIV_LAST) && (phase_reg == 2'd3);
    // ACK is read on the last clock of ph2, i.e. just before SCL has been
    // high for a full phase, giving the slave the whole low half to settle.
    assign ack_point = (div_reg == DIV_LAST) && (phase_reg == 2'd2);

    always_comb begin
        state_next    = state_reg;
        div_next      = div_reg;
        phase_next    = phase_reg;
        bit_next      = bit_reg;
        byte_idx_next = byte_idx_reg;
        ack_next      = ack_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        nack_err_next = nack_err_reg;
        load          = 1'b0;
`ifdef OLED_NACK_RETRY_EN
        retry_next      = retry_reg;
        retry_pend_next = retry_pend_reg;
`endif
        if (state_reg == IDLE) begin
            if (start && !busy_reg) begin
                load          = 1'b1;
                state_next    = START;
                busy_next     = 1'b1;
                nack_err_next = 1'b0;
                div_next      = '0;
                phase_next    = 2'd0;
`ifdef OLED_NACK_RETRY_EN
                retry_next      = '0;
                retry_pend_next = 1'b0;
`endif
            end
        end else begin
            div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
            if (div_reg == DIV_LAST)
                phase_next = phase_reg + 2'd1;
            if (ack_point && state_reg == ACKNOWLEDGE)
                ack_next = sda_in;
            if (slot_end) begin
                case (state_reg)
                    START: begin
                        state_next    = RECOGNITION;
                        bit_next      = 3'd7;
                        byte_idx_next = 2'd0;
                    end
                    RECOGNITION, WRITE_CONTROL, WRITE_COMMAND: begin
                        if (bit_reg == 3'd0)
                            state_next = ACKNOWLEDGE;
                        else
                            bit_next = bit_reg - 3'd1;
                    end
                    ACKNOWLEDGE: begin
                        bit_next = 3'd7;
                        if (ack_reg) begin
                            state_next = STOP;
`ifdef OLED_NACK_RETRY_EN
                            if (retry_reg == RTRY_W'(MAX_RETRY))
                                nack_err_next = 1'b1;
                            else
                                retry_pend_next = 1'b1;
`else
                            nack_err_next = 1'b1;
`endif
                        end else begin
                            case (byte_idx_reg)
                                2'd0: begin
                                    state_next    = WRITE_CONTROL;
                                    byte_idx_next = 2'd1;
                                end
                                2'd1: begin
                                    state_next    = WRITE_COMMAND;
                                    byte_idx_next = 2'd2;
                                end
                                default: state_next = STOP;
                            endcase
                        end
                    end
                    STOP: begin
`ifdef OLED_NACK_RETRY_EN
                        if (retry_pend_reg) begin
                            state_next      = START;
                            retry_next      = retry_reg + RTRY_W'(1);
                            retry_pend_next = 1'b0;
                        end else begin
                            state_next = IDLE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end
`else
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
`endif
                    end
                    default: state_next = IDLE;
                endcase
            end
        end

        case (byte_idx_next)
            2'd0:    sel_byte = addr_byte_reg;
            2'd1:    sel_byte = ctrl_byte_reg;
            default: sel_byte = cmd_byte_reg;
        endcase

        // Line levels are decoded from the next-state values and registered,
        // so SCL/SDA come straight from flops and cannot glitch.
        scl_next    = 1'b1;
        sda_oe_next = 1'b0;
        case (state_next)
            START: sda_oe_next = phase_next[1];
            RECOGNITION, WRITE_CONTROL, WRITE_COMMAND: begin
                scl_next    = phase_next[1];
                sda_oe_next = ~sel_byte[bit_next];
            end
            ACKNOWLEDGE: scl_next = phase_next[1];
            STOP: begin
                scl_next    = phase_next[1];
                sda_oe_next = (phase_next != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            div_reg       <= '0;
            phase_reg     <= 2'd0;
            bit_reg       <= 3'd0;
            byte_idx_reg  <= 2'd0;
            ack_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            nack_err_reg  <= 1'b0;
            scl_reg       <= 1'b1;
            sda_oe_reg    <= 1'b0;
            addr_byte_reg <= 8'h00;
            ctrl_byte_reg <= 8'h00;
            cmd_byte_reg  <= 8'h00;
        end else begin
            state_reg    <= state_next;
            div_reg      <= div_next;
            phase_reg    <= phase_next;
            bit_reg      <= bit_next;
            byte_idx_reg <= byte_idx_next;
            ack_reg      <= ack_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            nack_err_reg <= nack_err_next;
            scl_reg      <= scl_next;
            sda_oe_reg   <= sda_oe_next;
            if (load) begin
                addr_byte_reg <= {slave_addr, read_write};
                ctrl_byte_reg <= control_frame;
                cmd_byte_reg  <= reg_addr;
            end
        end
    end

    assign scl_out  = scl_reg;
    assign sda_oe   = sda_oe_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign nack_err = nack_err_reg;
    assign state    = state_reg;

endmodule

// File: tb/tb_i2c_oled_tx.sv
// ---------------------------------------------------------------------------
// tb_i2c_oled_tx
// Directed bench for i2c_oled_tx (CLK_DIV=4, MAX_RETRY=3). A passive bus
// monitor decodes START/STOP and bytes at SCL rise and acts as the slave,
// pulling SDA low in ACK slots unless told to NACK the address byte.
// ---------------------------------------------------------------------------
module tb_i2c_oled_tx;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic [6:0] slave_addr = 7'h00;
    logic       read_write = 1'b0;
    logic [7:0] control_frame = 8'h00;
    logic [7:0] reg_addr = 8'h00;
    logic       sda_in;
    logic       scl_out, sda_oe, busy, done, nack_err;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    i2c_oled_tx #(.CLK_DIV(4), .MAX_RETRY(3)) dut (
        .CLK(CLK), .RST(RST), .start(start), .slave_addr(slave_addr),
        .read_write(read_write), .control_frame(control_frame), .reg_addr(reg_addr),
        .sda_in(sda_in), .scl_out(scl_out), .sda_oe(sda_oe), .busy(busy),
        .done(done), .nack_err(nack_err), .state(state)
    );

    // ---------------- bus monitor / slave ----------------
    logic       ack_drive = 1'b0;
    logic       sda_line;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_busy = 1'b0;
    logic [3:0] prev_state_m = 4'd0;
    logic [7:0] shreg = 8'h00;
    int         bit_pos = 0, frame_bytes = 0;
    int         starts_seen = 0, stops_seen = 0, done_cnt = 0, busy_fall = 0, scl_falls = 0;
    int         nack_until = 0;  // attempts numbered <= this get their address NACKed
    logic [7:0] bytes_q[$];
    int         st_q[$];

    assign sda_line = ~sda_oe & ~ack_drive;
    assign sda_in   = sda_line;

    always @(negedge CLK) begin
        if (state != prev_state_m) st_q.push_back(int'(state));
        prev_state_m <= state;
        if (done) done_cnt <= done_cnt + 1;
        if (prev_busy && !busy) busy_fall <= busy_fall + 1;
        prev_busy <= busy;
        prev_scl  <= scl_out;
        prev_sda  <= sda_line;
        if (prev_scl && !scl_out) scl_falls <= scl_falls + 1;
        if (prev_scl && scl_out && prev_sda && !sda_line) begin
            starts_seen <= starts_seen + 1;
            bit_pos     <= 0;
            frame_bytes <= 0;
            ack_drive   <= 1'b0;
        end else if (prev_scl && scl_out && !prev_sda && sda_line) begin
            stops_seen <= stops_seen + 1;
            bit_pos    <= 0;
        end else if (!prev_scl && scl_out) begin
            if (bit_pos == 8) begin
                bit_pos <= 0;
            end else begin
                shreg <= {shreg[6:0], sda_line};
                if (bit_pos == 7) begin
                    bytes_q.push_back({shreg[6:0], sda_line});
                    frame_bytes <= frame_bytes + 1;
                end
                bit_pos <= bit_pos + 1;
            end
        end else if (prev_scl && !scl_out) begin
            ack_drive <= (bit_pos == 8) && !(frame_bytes == 1 && starts_seen <= nack_until);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [6:0] a, input logic rw, input logic [7:0] c, input logic [7:0] d);
        slave_addr = a; read_write = rw; control_frame = c; reg_addr = d; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    // cyc counts clock edges from the accept edge (accept edge = 1).
    task automatic wait_done(input int cyc0, output int cyc);
        cyc = cyc0;
        while (cyc < 3000) begin
            @(posedge CLK); #1;
            cyc++;
            if (done) break;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    int cyc, bb, sb, stb, db, fb, pb;

    initial begin
        // ---- reset state ----
        #23;
        chk("rst_scl", {31'b0, scl_out}, 32'd1);
        chk("rst_sda_oe", {31'b0, sda_oe}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_nack_err", {31'b0, nack_err}, 32'd0);
        chk("rst_state", {28'b0, state}, 32'd0);
        @(negedge CLK); RST = 1'b0;
        idle(3);
        $display("txn reset: released");

        // ---- nominal write, then back-to-back start in the done cycle ----
        nack_until = starts_seen;
        bb = bytes_q.size(); sb = starts_seen; db = done_cnt; fb = scl_falls; pb = stops_seen;
        launch(7'h3C, 1'b0, 8'h00, 8'hAF);
        chk("acc_state", {28'b0, state}, 32'd1);
        chk("acc_busy", {31'b0, busy}, 32'd1);
        wait_done(1, cyc);
        chk("nom_latency", cyc, 32'd465);
        chk("nom_nack_err", {31'b0, nack_err}, 32'd0);
        chk("done_cycle_scl", {31'b0, scl_out}, 32'd1);
        $display("txn nominal: done at cycle %0d", cyc);
        launch(7'h3C, 1'b0, 8'h40, 8'hA6);
        chk("b2b_state", {28'b0, state}, 32'd1);
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        chk("b2b_scl", {31'b0, scl_out}, 32'd1);
        chk("b2b_sda_oe", {31'b0, sda_oe}, 32'd0);
        chk("b2b_done_low", {31'b0, done}, 32'd0);
        wait_done(1, cyc);
        chk("b2b_latency", cyc, 32'd465);
        idle(2);
        chk("nom_byte_count", bytes_q.size() - bb, 32'd6);
        chk("nom_byte0", {24'b0, bytes_q[bb]}, 32'h78);
        chk("nom_byte1", {24'b0, bytes_q[bb + 1]}, 32'h00);
        chk("nom_byte2", {24'b0, bytes_q[bb + 2]}, 32'hAF);
        chk("b2b_byte0", {24'b0, bytes_q[bb + 3]}, 32'h78);
        chk("b2b_byte1", {24'b0, bytes_q[bb + 4]}, 32'h40);
        chk("b2b_byte2", {24'b0, bytes_q[bb + 5]}, 32'hA6);
        chk("b2b_starts", starts_seen - sb, 32'd2);
        chk("b2b_stops", stops_seen - pb, 32'd2);
        chk("b2b_dones", done_cnt - db, 32'd2);
        chk("b2b_scl_falls", scl_falls - fb, 32'd56);
        $display("txn back-to-back: done at cycle %0d", cyc);

`ifdef OLED_NACK_RETRY_EN
        // ---- slave NACKs every attempt: 4 STARTs, one done ----
        bb = bytes_q.size(); sb = starts_seen; db = done_cnt; pb = busy_fall;
        nack_until = starts_seen + 99;
        launch(7'h3C, 1'b0, 8'h00, 8'hAF);
        wait_done(1, cyc);
        chk("rty_all_latency", cyc, 32'd705);
        chk("rty_all_nack_err", {31'b0, nack_err}, 32'd1);
        idle(2);
        chk("rty_all_starts", starts_seen - sb, 32'd4);
        chk("rty_all_dones", done_cnt - db, 32'd1);
        chk("rty_all_busy_fall", busy_fall - pb, 32'd1);
        $display("txn retry-exhaust: done at cycle %0d", cyc);

        // ---- NACK on first attempt only ----
        bb = bytes_q.size(); sb = starts_seen;
        nack_until = starts_seen + 1;
        launch(7'h3C, 1'b0, 8'h00, 8'hAF);
        chk("rty_once_clear", {31'b0, nack_err}, 32'd0);
        wait_done(1, cyc);
        chk("rty_once_latency", cyc, 32'd641);
        chk("rty_once_nack_err", {31'b0, nack_err}, 32'd0);
        idle(2);
        chk("rty_once_starts", starts_seen - sb, 32'd2);
        chk("rty_once_bytes", bytes_q.size() - bb, 32'd4);
        chk("rty_once_last", {24'b0, bytes_q[bb + 3]}, 32'hAF);
        $display("txn retry-once: done at cycle %0d", cyc);
`else
        // ---- address NACK aborts ----
        bb = bytes_q.size(); sb = starts_seen; db = done_cnt; stb = st_q.size();
        nack_until = starts_seen + 1;
        launch(7'h3C, 1'b0, 8'h00, 8'hAF);
        wait_done(1, cyc);
        chk("nack_latency", cyc, 32'd177);
        chk("nack_err_set", {31'b0, nack_err}, 32'd1);
        idle(2);
        chk("nack_bytes", bytes_q.size() - bb, 32'd1);
        chk("nack_byte0", {24'b0, bytes_q[bb]}, 32'h78);
        chk("nack_starts", starts_seen - sb, 32'd1);
        chk("nack_dones", done_cnt - db, 32'd1);
        chk("nack_trace_len", st_q.size() - stb, 32'd5);
        chk("nack_trace_ack", st_q[stb + 2], 32'd7);
        chk("nack_trace_stop", st_q[stb + 3], 32'd8);
        chk("nack_trace_idle", st_q[stb + 4], 32'd0);
        $display("txn addr-nack: done at cycle %0d", cyc);
`endif

        // ---- start while busy with other data is ignored ----
        bb = bytes_q.size(); sb = starts_seen; db = done_cnt;
        nack_until = starts_seen;
        launch(7'h3C, 1'b0, 8'h00, 8'hAF);
        chk("accept_clears_nack", {31'b0, nack_err}, 32'd0);
        idle(40);
        launch(7'h11, 1'b1, 8'h40, 8'h55);
        wait_done(42, cyc);
        chk("ign_latency", cyc, 32'd465);
        idle(2);
        chk("ign_bytes", bytes_q.size() - bb, 32'd3);
        chk("ign_byte0", {24'b0, bytes_q[bb]}, 32'h78);
        chk("ign_byte2", {24'b0, bytes_q[bb + 2]}, 32'hAF);
        chk("ign_starts", starts_seen - sb, 32'd1);
        chk("ign_dones", done_cnt - db, 32'd1);
        $display("txn ignore-busy-start: done at cycle %0d", cyc);

        // ---- reset mid-byte: address bit 2 (0) at ph0, SCL low, SDA driven ----
        launch(7'h3C, 1'b0, 8'h00, 8'hAF);
        idle(99);
        chk("mid_pre_scl", {31'b0, scl_out}, 32'd0);
        chk("mid_pre_sda_oe", {31'b0, sda_oe}, 32'd1);
        #1 RST = 1'b1;
        #1;
        chk("mid_rst_scl", {31'b0, scl_out}, 32'd1);
        chk("mid_rst_sda_oe", {31'b0, sda_oe}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_state", {28'b0, state}, 32'd0);
        @(negedge CLK); RST = 1'b0;
        idle(5);
        $display("txn reset mid-byte");

        // ---- reset while idle ----
        #2 RST = 1'b1;
        #1;
        chk("idle_rst_scl", {31'b0, scl_out}, 32'd1);
        chk("idle_rst_state", {28'b0, state}, 32'd0);
        @(negedge CLK); RST = 1'b0;
        idle(3);

        // ---- recovery after reset ----
        bb = bytes_q.size();
        nack_until = starts_seen;
        launch(7'h3C, 1'b0, 8'h00, 8'hAF);
        wait_done(1, cyc);
        chk("rec_latency", cyc, 32'd465);
        idle(2);
        chk("rec_bytes", bytes_q.size() - bb, 32'd3);
        chk("rec_byte1", {24'b0, bytes_q[bb + 1]}, 32'h00);
        $display("txn recovery: done at cycle %0d", cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
